warp_controller: RTL
====================

Name: warp_controller

Overview:
- Per-warp sequencer that sits directly upstream of scalar_regs and the vector register file.
- Generates warp_state, which paces register read (WARP_REQUEST) and writeback (WARP_UPDATE).
- Owns the warp PC and supplies next_pc for link writes.
- Handshakes with the instruction fetcher and the LSU, and resolves branches/jumps once per instruction.

Parameters:
PC_BITS, 8, program-memory address width; PC arithmetic is modulo 2^PC_BITS
INSTR_BITS, 32, instruction word width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
warp_enable  in  1  dispatcher enable; low freezes all state and outputs
start  in  1  launch pulse; honoured only in WARP_IDLE or WARP_DONE
start_pc  in  PC_BITS  PC loaded on an honoured start
fetch_req  out  1  high throughout WARP_FETCH
fetch_valid  in  1  instruction valid from fetcher
fetch_instr  in  INSTR_BITS  fetched instruction
instr  out  INSTR_BITS  registered instruction held for the decoder
IsBR_J  in  2  from decoder: 0 none, 1 conditional branch, 2 jump
br_taken  in  1  branch condition result, valid in WARP_EXECUTE/WARP_UPDATE
br_target  in  PC_BITS  branch/jump target
DMemEN  in  1  from decoder: instruction uses the LSU
Halt  in  1  from decoder: return/halt instruction
lsu_req  out  1  one-cycle pulse to the LSU
lsu_done  in  1  LSU completion pulse
warp_state  out  3  warp_state_t: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7
pc  out  PC_BITS  current PC
next_pc  out  32  zero-extended (pc+1) mod 2^PC_BITS; combinational
done  out  1  high while in WARP_DONE
instr_count  out  32  retired-instruction counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, any state, including mid-instruction):
  - warp_state=IDLE; pc=0; instr=0; fetch_req=0; lsu_req=0; done=0; instr_count=0; done_flag cleared.
- warp_enable=0: no register changes, no new pulses; lsu_req deasserts; lsu_done still sets done_flag.
- IDLE: start -> FETCH, pc<=start_pc.
- FETCH: fetch_req=1.
  - fetch_valid sampled each cycle; when high, instr<=fetch_instr -> DECODE.
  - Stays in FETCH indefinitely without fetch_valid.
- DECODE: 1 cycle -> REQUEST.
- REQUEST: 1 cycle -> WAIT; lsu_req=1 in this cycle iff DMemEN.
- WAIT:
  - DMemEN=0: leave after 1 cycle -> EXECUTE.
  - DMemEN=1: leave when lsu_done or done_flag is set -> EXECUTE.
  - done_flag is sticky; it is set by lsu_done in REQUEST or WAIT and cleared on leaving WAIT. An early lsu_done is never lost.
- EXECUTE: 1 cycle -> UPDATE.
- UPDATE: 1 cycle, PC update with priority:
  - Halt -> DONE, pc unchanged.
  - IsBR_J==2 -> pc<=br_target.
  - IsBR_J==1 && br_taken -> pc<=br_target.
  - Otherwise pc<=pc+1, wrapping 2^PC_BITS-1 -> 0.
  - Non-halt -> FETCH.
- DONE: done=1; start -> FETCH with pc<=start_pc; otherwise hold.
- start outside IDLE/DONE is ignored.
- Minimum latency per non-memory instruction: 6 cycles (FETCH through UPDATE, fetch_valid on first FETCH cycle).
- next_pc is valid in UPDATE for link writes, since pc has not yet changed.

Optional Feature:
- WARP_INSTR_COUNT_EN defined: instr_count increments by 1 on every UPDATE cycle, including Halt, wrapping at 2^32. It is cleared by reset and by an honoured start.
- Undefined: instr_count is tied to 0 and no counter flops exist.

Test Plan:
1. Reset asserted mid-EXECUTE with pc=0x23 -> warp_state=IDLE, pc=0, done=0 immediately (asynchronous), and held while reset is high.
2. start, start_pc=0x10, fetch_valid on first FETCH cycle, ALU instr -> states 1,2,3,4,5,6 on consecutive cycles; next_pc=0x11 in UPDATE; pc=0x11 and state FETCH the following cycle.
3. Branch control at pc=0x10, br_target=0x40:
   - IsBR_J=1, br_taken=1 -> pc=0x40.
   - IsBR_J=1, br_taken=0 -> pc=0x11.
   - IsBR_J=2 -> pc=0x40.
   - pc=0xFF, no branch -> pc=0x00.
4. Load, DMemEN=1:
   - lsu_req pulses exactly once in REQUEST.
   - lsu_done after 4 WAIT cycles -> WAIT lasts 4 cycles.
   - lsu_done during REQUEST -> WAIT lasts 1 cycle.
5. warp_enable=0 for 3 cycles in WAIT and in FETCH (with fetch_valid=1) -> state, pc, instr unchanged; resumes on re-enable.
6. Halt in UPDATE -> DONE, done=1, pc unchanged; start, start_pc=0x05 -> FETCH, pc=0x05. With WARP_INSTR_COUNT_EN, 3 instructions -> instr_count=3.

Source files
------------

// File: rtl/warp_if.sv
`default_nettype none
// ============================================================================
// Module      : warp_if
// Description : Bundle of dispatcher, fetcher, decoder and LSU signals for
//               warp_controller. The controller uses the master modport and
//               its environment uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface warp_if #(
  parameter int PC_BITS    = 8,
  parameter int INSTR_BITS = 32
);
  logic                  warp_enable;
  logic                  start;
  logic [PC_BITS-1:0]    start_pc;
  logic                  fetch_req;
  logic                  fetch_valid;
  logic [INSTR_BITS-1:0] fetch_instr;
  logic [INSTR_BITS-1:0] instr;
  logic [1:0]            IsBR_J;
  logic                  br_taken;
  logic [PC_BITS-1:0]    br_target;
  logic                  DMemEN;
  logic                  Halt;
  logic                  lsu_req;
  logic                  lsu_done;
  logic [2:0]            warp_state;
  logic [PC_BITS-1:0]    pc;
  logic [31:0]           next_pc;
  logic                  done;
  logic [31:0]           instr_count;

  modport master (
    input  warp_enable, start, start_pc, fetch_valid, fetch_instr, IsBR_J,
           br_taken, br_target, DMemEN, Halt, lsu_done,
    output fetch_req, instr, lsu_req, warp_state, pc, next_pc, done,
           instr_count
  );

  modport slave (
    output warp_enable, start, start_pc, fetch_valid, fetch_instr, IsBR_J,
           br_taken, br_target, DMemEN, Halt, lsu_done,
    input  fetch_req, instr, lsu_req, warp_state, pc, next_pc, done,
           instr_count
  );
endinterface
`default_nettype wire

// File: rtl/warp_controller.sv
`default_nettype none
// ============================================================================
// Module      : warp_controller
// Description : Per-warp sequencer. Steps each instruction through
//               FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, owns the warp PC,
//               handshakes with the fetcher and LSU and resolves branches.
//               Optional macro WARP_INSTR_COUNT_EN adds a retired-instruction
//               counter; without it instr_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module warp_controller #(
  parameter int PC_BITS    = 8,
  parameter int INSTR_BITS = 32
) (
  input  wire logic clk,
  input  wire logic reset,
  warp_if.master    bus
);

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  warp_state_t           state_q, state_d;
  logic [PC_BITS-1:0]    pc_q, pc_d;
  logic [INSTR_BITS-1:0] instr_q, instr_d;
  logic                  done_flag_q, done_flag_d;
  logic [PC_BITS-1:0]    pc_inc;
  logic                  start_ok;
  logic                  fetch_req_d, lsu_req_d, done_d;

  assign pc_inc   = pc_q + {{(PC_BITS-1){1'b0}}, 1'b1};
  assign start_ok = bus.warp_enable && bus.start &&
                    (state_q == WARP_IDLE || state_q == WARP_DONE);

  // State, PC, instruction and LSU-completion flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WARP_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      done_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      done_flag_q <= done_flag_d;
    end
  end

  // Next-state, PC update and handshake outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    done_flag_d = done_flag_q;
    fetch_req_d = (state_q == WARP_FETCH);
    done_d      = (state_q == WARP_DONE);
    lsu_req_d   = 1'b0;

    // An LSU completion is captured even while disabled so it is never lost.
    if ((state_q == WARP_REQUEST || state_q == WARP_WAIT) && bus.lsu_done)
      done_flag_d = 1'b1;

    if (bus.warp_enable) begin
      case (state_q)
        WARP_IDLE, WARP_DONE: begin
          if (bus.start) begin
            state_d = WARP_FETCH;
            pc_d    = bus.start_pc;
          end
        end
        WARP_FETCH: begin
          if (bus.fetch_valid) begin
            instr_d = bus.fetch_instr;
            state_d = WARP_DECODE;
          end
        end
        WARP_DECODE:  state_d = WARP_REQUEST;
        WARP_REQUEST: begin
          lsu_req_d = bus.DMemEN;
          state_d   = WARP_WAIT;
        end
        WARP_WAIT: begin
          if (!bus.DMemEN || bus.lsu_done || done_flag_q) begin
            state_d     = WARP_EXECUTE;
            done_flag_d = 1'b0;
          end
        end
        WARP_EXECUTE: state_d = WARP_UPDATE;
        WARP_UPDATE: begin
          if (bus.Halt) begin
            state_d = WARP_DONE;
          end else begin
            state_d = WARP_FETCH;
            if (bus.IsBR_J == 2'd2 || (bus.IsBR_J == 2'd1 && bus.br_taken))
              pc_d = bus.br_target;
            else
              pc_d = pc_inc;
          end
        end
        default: state_d = WARP_IDLE;
      endcase
    end
  end

  assign bus.warp_state = state_q;
  assign bus.pc         = pc_q;
  assign bus.instr      = instr_q;
  assign bus.next_pc    = 32'(pc_inc);
  assign bus.fetch_req  = fetch_req_d;
  assign bus.lsu_req    = lsu_req_d;
  assign bus.done       = done_d;

`ifdef WARP_INSTR_COUNT_EN
  logic [31:0] count_q, count_d;

  // Retired-instruction count: restarts on launch, steps once per UPDATE.
  always_comb begin
    count_d = count_q;
    if (start_ok)
      count_d = '0;
    else if (bus.warp_enable && state_q == WARP_UPDATE)
      count_d = count_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign bus.instr_count = count_q;
`else
  logic unused_start_ok;
  assign unused_start_ok  = start_ok;
  assign bus.instr_count  = '0;
`endif

endmodule
`default_nettype wire
